// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending slot controller.
package vend_pkg;

    localparam int unsigned STOCK_W       = 4;
    localparam int unsigned MAX_STOCK_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DISPENSE,
        ST_COMMIT,
        ST_REJECT,
        ST_FAULT
    } vend_state_e;

    // Widened add so a full counter plus a full quantity cannot wrap before saturating.
    function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                   input logic [STOCK_W-1:0] b,
                                                   input logic [STOCK_W-1:0] lim);
        logic [STOCK_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[STOCK_W-1:0];
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Dispense watchdog: counts enabled cycles and flags the last allowed one.
module vend_timeout_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_c
);

    localparam int unsigned TW = $clog2(LIMIT + 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + TW'(1);
        end
    end

    assign expire_c = en_i && (count_q == TW'(LIMIT - 1));

endmodule

// File: rtl/vend_slot_controller.sv
// Vend/restock sequencer driving external per-slot stock counters and the dispense motor.
module vend_slot_controller
    import vend_pkg::*;
#(
    parameter  int unsigned NUM_SLOTS     = 4,
    parameter  int unsigned MAX_STOCK     = MAX_STOCK_DEF,
    parameter  int unsigned MOTOR_TIMEOUT = 255,
    localparam int unsigned SW            = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vend_req,
    input  logic [SW-1:0]                vend_slot,
    input  logic                         restock_req,
    input  logic [SW-1:0]                restock_slot,
    input  logic [STOCK_W-1:0]           restock_qty,
    input  logic                         motor_done,
    input  logic                         fault_clr,
    input  logic [STOCK_W*NUM_SLOTS-1:0] stock_q,
    output logic [STOCK_W*NUM_SLOTS-1:0] stock_d,
    output logic                         motor_en,
    output logic [SW-1:0]                motor_slot,
    output logic                         vend_ack,
    output logic                         vend_nack,
    output logic                         restock_ack,
    output logic                         busy,
    output logic                         fault
);

    localparam logic [STOCK_W-1:0] LIM    = STOCK_W'(MAX_STOCK);
    localparam logic [SW:0]        NSLOTS = (SW + 1)'(NUM_SLOTS);

    vend_state_e        state_q, state_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [STOCK_W-1:0] vend_cnt, rs_cnt;
    logic               vend_in_range, rs_in_range;
    logic               tmr_expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    vend_timeout_timer #(
        .LIMIT (MOTOR_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (state_q != ST_DISPENSE),
        .en_i     (state_q == ST_DISPENSE),
        .expire_c (tmr_expire)
    );

    assign vend_in_range = ({1'b0, slot_q} < NSLOTS);
    assign rs_in_range   = ({1'b0, restock_slot} < NSLOTS);

    // Current counts of the latched vend slot and the requested restock slot.
    always_comb begin
        vend_cnt = '0;
        rs_cnt   = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_q == SW'(i)) begin
                vend_cnt = stock_q[i*STOCK_W +: STOCK_W];
            end
            if (restock_slot == SW'(i)) begin
                rs_cnt = stock_q[i*STOCK_W +: STOCK_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        stock_d     = stock_q;
        restock_ack = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vend_req) begin
                    slot_d  = vend_slot;
                    state_d = ST_CHECK;
                end else if (restock_req && rs_in_range) begin
                    restock_ack = 1'b1;
                    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                        if (restock_slot == SW'(i)) begin
                            stock_d[i*STOCK_W +: STOCK_W] = sat_add(rs_cnt, restock_qty, LIM);
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (!vend_in_range || (vend_cnt == '0)) begin
                    state_d = ST_REJECT;
                end else begin
                    state_d = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                // A drop reported on the final allowed cycle still completes the vend.
                if (motor_done) begin
                    state_d = ST_COMMIT;
                end else if (tmr_expire) begin
                    state_d = ST_FAULT;
                end
            end
            ST_COMMIT: begin
                for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                    if (slot_q == SW'(i)) begin
                        stock_d[i*STOCK_W +: STOCK_W] = vend_cnt - STOCK_W'(1);
                    end
                end
                state_d = ST_IDLE;
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode the state register directly so reset silences them at once.
    assign motor_en   = (state_q == ST_DISPENSE);
    assign motor_slot = slot_q;
    assign vend_ack   = (state_q == ST_COMMIT);
    assign vend_nack  = (state_q == ST_REJECT);
    assign busy       = (state_q != ST_IDLE);
    assign fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_vend_slot_controller.sv
// Directed plus randomized bench; emulates the stock counters and tracks expected stock arithmetically.
module tb_vend_slot_controller;

    localparam int unsigned NS = 4;
    localparam int unsigned TO = 8;
    localparam int          MAXS = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        vend_req, restock_req, motor_done, fault_clr;
    logic [1:0]  vend_slot, restock_slot, motor_slot;
    logic [3:0]  restock_qty;
    logic [15:0] stock_q, stock_d;
    logic        motor_en, vend_ack, vend_nack, restock_ack, busy, fault;
    logic        pre_en;
    logic [15:0] pre_val;

    int n_total = 0;
    int n_pass  = 0;
    int mstock[NS];

    always #5 clk = ~clk;

    always_ff @(posedge clk) stock_q <= pre_en ? pre_val : stock_d;

    vend_slot_controller #(
        .NUM_SLOTS     (NS),
        .MAX_STOCK     (15),
        .MOTOR_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vend_req     (vend_req),
        .vend_slot    (vend_slot),
        .restock_req  (restock_req),
        .restock_slot (restock_slot),
        .restock_qty  (restock_qty),
        .motor_done   (motor_done),
        .fault_clr    (fault_clr),
        .stock_q      (stock_q),
        .stock_d      (stock_d),
        .motor_en     (motor_en),
        .motor_slot   (motor_slot),
        .vend_ack     (vend_ack),
        .vend_nack    (vend_nack),
        .restock_ack  (restock_ack),
        .busy         (busy),
        .fault        (fault)
    );

    function automatic logic [15:0] model_pack();
        logic [15:0] v;
        for (int i = 0; i < int'(NS); i++) v[i*4 +: 4] = 4'(mstock[i]);
        return v;
    endfunction

    function automatic int sat(input int a, input int b);
        return (a + b > MAXS) ? MAXS : a + b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [15:0] v);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_val = v;
        @(negedge clk);
        pre_en = 1'b0;
        for (int i = 0; i < int'(NS); i++) mstock[i] = int'(v[i*4 +: 4]);
    endtask

    task automatic do_restock(input int s, input int q);
        int e;
        @(negedge clk);
        restock_req  = 1'b1;
        restock_slot = 2'(s);
        restock_qty  = 4'(q);
        #1;
        e = sat(mstock[s], q);
        chk("restock_ack", 32'(restock_ack), 1);
        chk("restock_d", 32'(stock_d[s*4 +: 4]), e);
        mstock[s] = e;
        @(negedge clk);
        restock_req = 1'b0;
        #1;
        chk("restock_q", 32'(stock_q), 32'(model_pack()));
    endtask

    task automatic fault_seq();
        chk("fault_set", 32'(fault), 1);
        chk("fault_motor", 32'(motor_en), 0);
        repeat (3) begin
            @(negedge clk);
            vend_req     = 1'b1;
            vend_slot    = 2'($urandom_range(0, 3));
            restock_req  = 1'b1;
            restock_slot = 2'($urandom_range(0, 3));
            restock_qty  = 4'($urandom_range(1, 15));
            #1;
            chk("fault_hold", 32'(fault), 1);
            chk("fault_no_rs_ack", 32'(restock_ack), 0);
            chk("fault_stock_d", 32'(stock_d), 32'(model_pack()));
        end
        @(negedge clk);
        vend_req    = 1'b0;
        restock_req = 1'b0;
        fault_clr   = 1'b1;
        #1;
        chk("fault_before_clr", 32'(fault), 1);
        @(negedge clk);
        fault_clr = 1'b0;
        #1;
        chk("fault_cleared", 32'(fault), 0);
        chk("fault_idle", 32'(busy), 0);
        chk("fault_stock_q", 32'(stock_q), 32'(model_pack()));
    endtask

    // d = DISPENSE cycle (1-based) on which motor_done pulses; d > TO means never.
    task automatic do_vend(input int s, input int d);
        int  k;
        bit  done;
        @(negedge clk);
        vend_req  = 1'b1;
        vend_slot = 2'(s);
        #1;
        chk("accept_idle", 32'(busy), 0);
        @(negedge clk);
        vend_req = 1'b0;
        #1;
        chk("check_busy", 32'(busy), 1);
        chk("check_motor", 32'(motor_en), 0);
        if (mstock[s] == 0) begin
            @(negedge clk);
            #1;
            chk("nack", 32'(vend_nack), 1);
            chk("nack_motor", 32'(motor_en), 0);
            chk("nack_no_ack", 32'(vend_ack), 0);
            @(negedge clk);
            #1;
            chk("nack_idle", 32'(busy), 0);
            chk("nack_stock", 32'(stock_q), 32'(model_pack()));
        end else begin
            k    = 1;
            done = 1'b0;
            while (k <= int'(TO) && !done) begin
                @(negedge clk);
                motor_done = (k == d);
                #1;
                chk("disp_motor", 32'(motor_en), 1);
                chk("disp_slot", 32'(motor_slot), s);
                done = (k == d);
                k++;
            end
            @(negedge clk);
            motor_done = 1'b0;
            #1;
            if (d <= int'(TO)) begin
                chk("vend_ack", 32'(vend_ack), 1);
                chk("commit_d", 32'(stock_d[s*4 +: 4]), mstock[s] - 1);
                mstock[s]--;
                @(negedge clk);
                #1;
                chk("commit_q", 32'(stock_q), 32'(model_pack()));
                chk("commit_idle", 32'(busy), 0);
            end else begin
                fault_seq();
            end
        end
    endtask

    initial begin
        int q;
        reset        = 1'b0;
        vend_req     = 1'b0;
        vend_slot    = '0;
        restock_req  = 1'b0;
        restock_slot = '0;
        restock_qty  = '0;
        motor_done   = 1'b0;
        fault_clr    = 1'b0;
        pre_en       = 1'b1;
        pre_val      = 16'h530C;
        #12;
        chk("rst_motor_en", 32'(motor_en), 0);
        chk("rst_vend_ack", 32'(vend_ack), 0);
        chk("rst_vend_nack", 32'(vend_nack), 0);
        chk("rst_restock_ack", 32'(restock_ack), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_motor_slot", 32'(motor_slot), 0);
        chk("rst_stock_pass", 32'(stock_d), 32'h530C);
        @(negedge clk);
        reset  = 1'b1;
        pre_en = 1'b0;
        for (int i = 0; i < int'(NS); i++) mstock[i] = int'(pre_val[i*4 +: 4]);

        // Normal vend with motor_done on the 2nd DISPENSE cycle, then an empty slot.
        do_vend(2, 2);
        do_vend(1, 1);

        // Restock saturation and plain add.
        do_restock(0, 7);
        preload(16'h5203);
        do_restock(0, 4);

        // Simultaneous vend and restock: vend first, restock right after.
        q = 6;
        @(negedge clk);
        vend_req     = 1'b1;
        vend_slot    = 2'd3;
        restock_req  = 1'b1;
        restock_slot = 2'd0;
        restock_qty  = 4'(q);
        #1;
        chk("sim_no_rs_ack_idle", 32'(restock_ack), 0);
        chk("sim_stock_idle", 32'(stock_d), 32'(model_pack()));
        @(negedge clk);
        vend_req = 1'b0;
        #1;
        chk("sim_no_rs_ack_check", 32'(restock_ack), 0);
        @(negedge clk);
        motor_done = 1'b1;
        #1;
        chk("sim_motor", 32'(motor_en), 1);
        chk("sim_no_rs_ack_disp", 32'(restock_ack), 0);
        @(negedge clk);
        motor_done = 1'b0;
        #1;
        chk("sim_vend_ack", 32'(vend_ack), 1);
        chk("sim_no_rs_ack_commit", 32'(restock_ack), 0);
        chk("sim_commit_d", 32'(stock_d[15:12]), mstock[3] - 1);
        mstock[3]--;
        @(negedge clk);
        #1;
        chk("sim_rs_ack", 32'(restock_ack), 1);
        chk("sim_rs_d", 32'(stock_d[3:0]), sat(mstock[0], q));
        mstock[0] = sat(mstock[0], q);
        @(negedge clk);
        restock_req = 1'b0;
        #1;
        chk("sim_stock_q", 32'(stock_q), 32'(model_pack()));

        // Timeout boundary: drop on the last allowed cycle wins; no drop faults.
        do_vend(3, int'(TO));
        do_vend(2, 20);

        // Asynchronous reset in the middle of DISPENSE.
        @(negedge clk);
        vend_req  = 1'b1;
        vend_slot = 2'd0;
        @(negedge clk);
        vend_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid_motor_on", 32'(motor_en), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_motor_off", 32'(motor_en), 0);
        chk("rstmid_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_no_ack", 32'(vend_ack), 0);
        chk("rstmid_stock_d", 32'(stock_d), 32'(model_pack()));
        @(negedge clk);
        #1;
        chk("rstmid_stock_q", 32'(stock_q), 32'(model_pack()));

        // Randomized mix of vends (some timing out) and restocks.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_restock(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            end else begin
                do_vend(int'($urandom_range(0, 3)), int'($urandom_range(1, 10)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
